// File: rtl/param_rx_bank_if.sv
// Byte-stream input and parameter-bank output bundle for param_rx_bank.
interface param_rx_bank_if #(
    parameter int unsigned NUM_PARAMS      = 4,
    parameter int unsigned BYTES_PER_PARAM = 3
);
    logic [7:0]                               i_data;
    logic                                     i_data_valid;
    logic                                     i_param_ready;
    logic [NUM_PARAMS*BYTES_PER_PARAM*8-1:0]  o_params;
    logic                                     o_params_valid;
    logic                                     o_frame_ok;
    logic                                     o_frame_err;
    logic [7:0]                               o_err_count;

    // Byte source and bank consumer.
    modport master (
        output i_data, i_data_valid, i_param_ready,
        input  o_params, o_params_valid, o_frame_ok, o_frame_err, o_err_count
    );

    // The receiver itself.
    modport slave (
        input  i_data, i_data_valid, i_param_ready,
        output o_params, o_params_valid, o_frame_ok, o_frame_err, o_err_count
    );
endinterface

// File: rtl/param_rx_bank.sv
// Frame receiver: header, big-endian payload words, XOR checksum. Good frames
// commit to an internal bank that is forwarded to the output bank when allowed.
module param_rx_bank #(
    parameter int unsigned NUM_PARAMS      = 4,
    parameter int unsigned BYTES_PER_PARAM = 3,
    parameter logic [7:0]  HEADER_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input logic            i_clk,
    input logic            i_rst_n,
    param_rx_bank_if.slave io_bus
);
    localparam int unsigned NBYTES    = NUM_PARAMS * BYTES_PER_PARAM;
    localparam int unsigned BANK_W    = NBYTES * 8;
    localparam logic [6:0]  LAST_BYTE = 7'(NBYTES - 1);
    localparam logic [15:0] TIMEOUT   = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StPayload, StCsum} state_e;

    state_e              r_state, w_state_d;
    logic [6:0]          r_byte_cnt, w_byte_cnt_d;
    logic [7:0]          r_xor, w_xor_d;
    logic [15:0]         r_gap, w_gap_d;
    logic                w_stage_we, w_commit, w_err;
    logic [BANK_W-1:0]   r_stage, r_bank, r_out;
    logic                r_have_good, r_params_valid, r_frame_ok, r_frame_err;
    logic [7:0]          r_err_count;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    // Next state, frame counters and commit/error decisions.
    always_comb begin
        w_state_d    = r_state;
        w_byte_cnt_d = r_byte_cnt;
        w_xor_d      = r_xor;
        w_gap_d      = r_gap;
        w_stage_we   = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            StIdle: begin
                if (io_bus.i_data_valid && io_bus.i_data == HEADER_BYTE) begin
                    w_state_d    = StPayload;
                    w_byte_cnt_d = '0;
                    w_xor_d      = '0;
                    w_gap_d      = '0;
                end
            end
            StPayload, StCsum: begin
                // Timeout wins over a byte offered in the same cycle.
                if (r_gap == TIMEOUT) begin
                    w_state_d = StIdle;
                    w_gap_d   = '0;
                    w_err     = 1'b1;
                end else if (io_bus.i_data_valid) begin
                    w_gap_d = '0;
                    if (r_state == StPayload) begin
                        w_stage_we = 1'b1;
                        w_xor_d    = r_xor ^ io_bus.i_data;
                        if (r_byte_cnt == LAST_BYTE) w_state_d = StCsum;
                        else                         w_byte_cnt_d = r_byte_cnt + 7'd1;
                    end else begin
                        w_state_d = StIdle;
                        if (io_bus.i_data == r_xor) w_commit = 1'b1;
                        else                        w_err    = 1'b1;
                    end
                end else begin
                    w_gap_d = r_gap + 16'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Frame bookkeeping registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt <= '0;
            r_xor      <= '0;
            r_gap      <= '0;
        end else begin
            r_byte_cnt <= w_byte_cnt_d;
            r_xor      <= w_xor_d;
            r_gap      <= w_gap_d;
        end
    end

    // Staging bank: payload byte i lands in word i/B, MSB-first within the word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= '0;
        end else if (w_stage_we) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (r_byte_cnt == 7'(i)) begin
                    r_stage[((i / BYTES_PER_PARAM) * BYTES_PER_PARAM
                             + (BYTES_PER_PARAM - 1 - (i % BYTES_PER_PARAM))) * 8 +: 8]
                        <= io_bus.i_data;
                end
            end
        end
    end

    // Internal bank, result pulses and saturating error count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bank      <= '0;
            r_have_good <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_frame_ok  <= w_commit;
            r_frame_err <= w_err;
            if (w_commit) begin
                r_bank      <= r_stage;
                r_have_good <= 1'b1;
            end
            if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
    end

    // Output bank follows the pre-update internal bank while the consumer allows it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out          <= '0;
            r_params_valid <= 1'b0;
        end else if (io_bus.i_param_ready && r_have_good) begin
            r_out          <= r_bank;
            r_params_valid <= 1'b1;
        end
    end

    assign io_bus.o_params       = r_out;
    assign io_bus.o_params_valid = r_params_valid;
    assign io_bus.o_frame_ok     = r_frame_ok;
    assign io_bus.o_frame_err    = r_frame_err;
    assign io_bus.o_err_count    = r_err_count;
endmodule
